// File: rtl/enemy_pkg.sv
// Shared types and helpers for the enemy missile launch path:
// controller states, screen/base geometry and the start-X LFSR step.
package enemy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ALLOC,
        ST_LAUNCH,
        ST_DONE
    } launch_state_t;

    localparam int unsigned TGT_IDX_W  = 3;
    localparam int unsigned SLOT_IDX_W = 3;
    localparam int unsigned X_W        = 10;
    localparam int unsigned SCREEN_W   = 640;

    localparam int unsigned DEF_BASE_X0 = 80;
    localparam int unsigned DEF_BASE_X1 = 320;
    localparam int unsigned DEF_BASE_X2 = 560;

    // Galois form of x^10 + x^7 + 1, right-shifting
    localparam logic [X_W-1:0] LFSR_TAPS = 10'h240;
    localparam logic [X_W-1:0] LFSR_SEED = 10'h1A5;

    function automatic logic [X_W-1:0] lfsr_step(input logic [X_W-1:0] v);
        return {1'b0, v[X_W-1:1]} ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

    function automatic logic [X_W-1:0] clip_start_x(input logic [X_W-1:0] v);
        return (v >= X_W'(SCREEN_W)) ? v - X_W'(512) : v;
    endfunction

    // Out-of-range target indices fall back to the centre base
    function automatic logic [X_W-1:0] target_to_x(
        input logic [TGT_IDX_W-1:0] idx,
        input logic [X_W-1:0]       bx0,
        input logic [X_W-1:0]       bx1,
        input logic [X_W-1:0]       bx2
    );
        case (idx)
            3'd0:    return bx0;
            3'd2:    return bx2;
            default: return bx1;
        endcase
    endfunction

endpackage

// File: rtl/lowest_free_slot_enc.sv
// Priority encoder: index of the lowest set slot_free bit plus an any-free flag.
module lowest_free_slot_enc
    import enemy_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic [NUM_SLOTS-1:0]  slot_free,
    output logic [SLOT_IDX_W-1:0] slot_idx,
    output logic                  any_free
);

    always_comb begin
        slot_idx = '0;
        any_free = |slot_free;
        // Scan downward so the lowest free index wins
        for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
            if (slot_free[i-1]) begin
                slot_idx = SLOT_IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/enemy_missile_launch_ctrl.sv
// Paces a wave of enemy missiles: interval wait, free-slot allocation,
// target/start X latch and a valid/ready launch to the slot bank.
module enemy_missile_launch_ctrl
    import enemy_pkg::*;
#(
    parameter int unsigned NUM_SLOTS       = 4,
    parameter int unsigned WAVE_SIZE       = 10,
    parameter int unsigned LAUNCH_INTERVAL = 30,
    parameter int unsigned BASE_X0         = DEF_BASE_X0,
    parameter int unsigned BASE_X1         = DEF_BASE_X1,
    parameter int unsigned BASE_X2         = DEF_BASE_X2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 wave_start,
    input  logic                 game_active,
    input  logic [2:0]           target_sel,
    input  logic [NUM_SLOTS-1:0] slot_free,
    input  logic                 launch_ready,
    output logic                 launch_valid,
    output logic [2:0]           launch_slot,
    output logic [9:0]           launch_target_x,
    output logic [9:0]           launch_start_x,
    output logic [7:0]           remaining,
    output logic                 wave_done
);

    localparam int unsigned CNT_W = (LAUNCH_INTERVAL > 1) ? $clog2(LAUNCH_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAUNCH_INTERVAL - 1);

    launch_state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            rem_q, rem_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic [SLOT_IDX_W-1:0] slot_q, slot_d;
    logic [X_W-1:0]        tx_q, tx_d;
    logic [X_W-1:0]        sx_q, sx_d;
    logic [X_W-1:0]        lfsr_q;

    logic [SLOT_IDX_W-1:0] enc_idx;
    logic                  enc_any;

    lowest_free_slot_enc #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_enc (
        .slot_free (slot_free),
        .slot_idx  (enc_idx),
        .any_free  (enc_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            slot_q  <= '0;
            tx_q    <= '0;
            sx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            slot_q  <= slot_d;
            tx_q    <= tx_d;
            sx_q    <= sx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        done_d  = done_q;
        valid_d = valid_q;
        slot_d  = slot_q;
        tx_d    = tx_q;
        sx_d    = sx_q;

        // Abort overrides every state; wave_done is deliberately left alone
        if (!game_active) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            rem_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (wave_start) begin
                        state_d = ST_WAIT;
                        rem_d   = 8'(WAVE_SIZE);
                        done_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT: begin
                    if (frame_tick) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_ALLOC;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_ALLOC: begin
                    if (enc_any) begin
                        state_d = ST_LAUNCH;
                        valid_d = 1'b1;
                        slot_d  = enc_idx;
                        tx_d    = target_to_x(target_sel, X_W'(BASE_X0),
                                              X_W'(BASE_X1), X_W'(BASE_X2));
                        sx_d    = clip_start_x(lfsr_q);
                    end
                end
                ST_LAUNCH: begin
                    if (launch_ready) begin
                        valid_d = 1'b0;
                        rem_d   = rem_q - 1'b1;
                        cnt_d   = '0;
                        if (rem_q == 8'd1) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign launch_valid    = valid_q;
    assign launch_slot     = slot_q;
    assign launch_target_x = tx_q;
    assign launch_start_x  = sx_q;
    assign remaining       = rem_q;
    assign wave_done       = done_q;

endmodule

// File: tb/tb_enemy_missile_launch_ctrl.sv
// Bench for enemy_missile_launch_ctrl: directed scenarios plus random traffic,
// every cycle compared with a wave-level behavioural model.
module tb_enemy_missile_launch_ctrl;

    localparam int NS = 4;
    localparam int WS = 5;
    localparam int LI = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_tick = 1'b0;
    logic          wave_start = 1'b0;
    logic          game_active = 1'b0;
    logic [2:0]    target_sel = 3'd0;
    logic [NS-1:0] slot_free = '0;
    logic          launch_ready = 1'b0;
    logic          launch_valid;
    logic [2:0]    launch_slot;
    logic [9:0]    launch_target_x;
    logic [9:0]    launch_start_x;
    logic [7:0]    remaining;
    logic          wave_done;

    enemy_missile_launch_ctrl #(
        .NUM_SLOTS       (NS),
        .WAVE_SIZE       (WS),
        .LAUNCH_INTERVAL (LI),
        .BASE_X0         (80),
        .BASE_X1         (320),
        .BASE_X2         (560)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick      (frame_tick),
        .wave_start      (wave_start),
        .game_active     (game_active),
        .target_sel      (target_sel),
        .slot_free       (slot_free),
        .launch_ready    (launch_ready),
        .launch_valid    (launch_valid),
        .launch_slot     (launch_slot),
        .launch_target_x (launch_target_x),
        .launch_start_x  (launch_start_x),
        .remaining       (remaining),
        .wave_done       (wave_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Wave-level model: a wave is idle, counting ticks, looking for a slot,
    // offering a launch, or finished.
    localparam int P_IDLE = 0, P_COUNT = 1, P_SEEK = 2, P_OFFER = 3, P_DONE = 4;
    int m_phase = P_IDLE;
    int m_ticks = 0;
    int m_left  = 0;
    int m_done  = 0;
    int m_valid = 0;
    int m_slot  = 0;
    int m_tx    = 0;
    int m_sx    = 0;
    int m_rng   = 'h1A5;

    function automatic int base_for(input int idx);
        if (idx == 0) return 80;
        if (idx == 2) return 560;
        return 320;
    endfunction

    always @(posedge clk) begin
        int cur;
        if (!rst_n) begin
            m_phase = P_IDLE; m_ticks = 0; m_left = 0; m_done = 0;
            m_valid = 0; m_slot = 0; m_tx = 0; m_sx = 0; m_rng = 'h1A5;
        end else begin
            cur = m_rng;
            m_rng = (cur % 2 == 1) ? ((cur / 2) ^ 'h240) : (cur / 2);
            if (!game_active) begin
                m_phase = P_IDLE; m_valid = 0; m_left = 0;
            end else if (m_phase == P_IDLE || m_phase == P_DONE) begin
                if (wave_start) begin
                    m_phase = P_COUNT; m_left = WS; m_done = 0; m_ticks = 0;
                end
            end else if (m_phase == P_COUNT) begin
                if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks == LI) begin
                        m_phase = P_SEEK; m_ticks = 0;
                    end
                end
            end else if (m_phase == P_SEEK) begin
                if (slot_free != 0) begin
                    m_slot = -1;
                    for (int i = 0; i < NS; i++)
                        if (m_slot < 0 && slot_free[i]) m_slot = i;
                    m_tx = base_for(int'(target_sel));
                    m_sx = (cur >= 640) ? cur - 512 : cur;
                    m_valid = 1;
                    m_phase = P_OFFER;
                end
            end else if (m_phase == P_OFFER) begin
                if (launch_ready) begin
                    m_valid = 0;
                    m_left--;
                    m_ticks = 0;
                    if (m_left == 0) begin
                        m_phase = P_DONE; m_done = 1;
                    end else begin
                        m_phase = P_COUNT;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        chk("valid_vs_model", int'(launch_valid), m_valid);
        chk("remaining_vs_model", int'(remaining), m_left);
        chk("wave_done_vs_model", int'(wave_done), m_done);
        if (m_valid != 0) begin
            chk("slot_vs_model", int'(launch_slot), m_slot);
            chk("target_x_vs_model", int'(launch_target_x), m_tx);
            chk("start_x_vs_model", int'(launch_start_x), m_sx);
        end
    end

    int tick_ctr = 0;
    bit tick_en = 0;
    bit rand_mode = 0;

    task automatic cyc();
        @(negedge clk);
        tick_ctr++;
        if (!rand_mode) begin
            frame_tick = tick_en && (tick_ctr % 4 == 0);
        end else begin
            rst_n        = ($urandom_range(0, 599) != 0);
            wave_start   = ($urandom_range(0, 19) == 0);
            game_active  = ($urandom_range(0, 149) != 0);
            frame_tick   = ($urandom_range(0, 2) == 0);
            slot_free    = ($urandom_range(0, 3) == 0) ? '0 : NS'($urandom);
            launch_ready = $urandom_range(0, 1) != 0;
            target_sel   = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!launch_valid && n < budget) begin
            cyc();
            n++;
        end
        if (!launch_valid) chk(name, 0, 1);
    endtask

    initial begin
        int tsel[3] = '{1, 2, 5};
        int txe[3]  = '{320, 560, 320};
        int nv;
        bit stable;
        logic [2:0] h_slot;
        logic [9:0] h_tx, h_sx;

        repeat (3) cyc();
        chk("reset_valid", int'(launch_valid), 0);
        chk("reset_slot", int'(launch_slot), 0);
        chk("reset_target_x", int'(launch_target_x), 0);
        chk("reset_start_x", int'(launch_start_x), 0);
        chk("reset_remaining", int'(remaining), 0);
        chk("reset_wave_done", int'(wave_done), 0);

        rst_n = 1; game_active = 1; slot_free = 4'hF; launch_ready = 1;
        target_sel = 0; tick_en = 1;
        cyc();
        wave_start = 1;
        cyc();
        wave_start = 0;
        chk("start_remaining", int'(remaining), WS);
        chk("start_done", int'(wave_done), 0);

        wait_valid(60, "first_launch_timeout");
        chk("first_slot", int'(launch_slot), 0);
        chk("first_target_x", int'(launch_target_x), 80);
        chk("first_start_x_range", int'(launch_start_x < 10'd640), 1);
        cyc();
        chk("first_valid_drop", int'(launch_valid), 0);
        chk("first_remaining", int'(remaining), WS - 1);

        for (int k = 0; k < 3; k++) begin
            target_sel = 3'(tsel[k]);
            wait_valid(60, "target_launch_timeout");
            chk("target_map_x", int'(launch_target_x), txe[k]);
            cyc();
            chk("target_remaining", int'(remaining), WS - 2 - k);
        end

        slot_free = '0; launch_ready = 0; nv = 0;
        repeat (40) begin
            cyc();
            if (launch_valid) nv++;
        end
        chk("no_slot_no_valid", nv, 0);
        slot_free = 4'b0100;
        wait_valid(5, "slot_free_timeout");
        chk("freed_slot_index", int'(launch_slot), 2);

        h_slot = launch_slot; h_tx = launch_target_x; h_sx = launch_start_x;
        stable = 1;
        repeat (7) begin
            cyc();
            if (!launch_valid || launch_slot != h_slot || launch_target_x != h_tx ||
                launch_start_x != h_sx || remaining != 8'd1) stable = 0;
        end
        chk("backpressure_stable", int'(stable), 1);
        launch_ready = 1;
        cyc();
        chk("last_valid_drop", int'(launch_valid), 0);
        chk("last_remaining", int'(remaining), 0);
        chk("wave_done_set", int'(wave_done), 1);

        nv = 0;
        repeat (30) begin
            cyc();
            if (launch_valid) nv++;
        end
        chk("done_no_launch", nv, 0);
        chk("done_sticky", int'(wave_done), 1);
        wave_start = 1;
        cyc();
        wave_start = 0;
        chk("restart_remaining", int'(remaining), WS);
        chk("restart_done_clear", int'(wave_done), 0);

        launch_ready = 0; slot_free = 4'hF;
        wait_valid(60, "abort_launch_timeout");
        game_active = 0;
        cyc();
        chk("abort_valid", int'(launch_valid), 0);
        chk("abort_remaining", int'(remaining), 0);
        chk("abort_done_kept", int'(wave_done), 0);

        game_active = 1; wave_start = 1;
        cyc();
        wave_start = 0;
        wait_valid(60, "reset_launch_timeout");
        rst_n = 0;
        #1;
        chk("async_reset_valid", int'(launch_valid), 0);
        chk("async_reset_remaining", int'(remaining), 0);
        cyc();
        cyc();
        rst_n = 1;

        rand_mode = 1;
        repeat (4000) cyc();
        rand_mode = 0;
        rst_n = 1;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
